// File: rtl/freq_counter_pkg.sv
// Shared definitions for the frequency counter.
// Contents:
//   DEFAULT_GATE_CYCLES - default gate length in clk_in cycles
//   DEFAULT_NUM_DIGITS  - default number of cascaded BCD digits
//   state_t             - gate controller state encoding
package freq_counter_pkg;

    localparam int DEFAULT_GATE_CYCLES = 1000000;
    localparam int DEFAULT_NUM_DIGITS  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_LATCH,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous signal into the clk_in domain and flags its rising
// edges.
// Ports:
//   clk_in     - clock
//   reset_n_in - asynchronous active-low reset
//   signal_in  - unsynchronised input
//   edge_out   - one-cycle pulse per rising edge of signal_in
module sync_edge_detect (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic signal_in,
    output logic edge_out
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; a blocking chain would
    // collapse the synchroniser into a single stage.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= signal_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign edge_out = sync2_q & ~hist_q;

endmodule

// File: rtl/freq_gate_controller.sv
// Gate controller for a BCD frequency counter: clears the external digit
// chain, enables it for exactly GATE_CYCLES clocks while feeding it
// synchronised edge pulses, then latches the chain value and offers it on a
// valid/ready handshake.
// Ports:
//   clk_in, reset_n_in           - clock, asynchronous active-low reset
//   signal_in                    - measured signal (asynchronous)
//   start_in, continuous_in      - start one / run back-to-back measurements
//   abort_in                     - cancel a measurement in progress
//   digits_in, overflow_in       - live chain value and MSD carry out
//   cnt_reset_out/enable/pulse   - controls to the digit chain
//   result_out, overflow_out     - latched measurement and overflow flag
//   result_valid_out/ready_in    - result handshake
//   busy_out                     - controller not idle
module freq_gate_controller
    import freq_counter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic                    signal_in,
    input  logic                    start_in,
    input  logic                    continuous_in,
    input  logic                    abort_in,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    overflow_in,
    output logic                    cnt_reset_out,
    output logic                    cnt_enable_out,
    output logic                    cnt_pulse_out,
    output logic [4*NUM_DIGITS-1:0] result_out,
    output logic                    overflow_out,
    output logic                    result_valid_out,
    input  logic                    result_ready_in,
    output logic                    busy_out
);

    localparam int TIMER_W = $clog2(GATE_CYCLES);

    state_t               state_q;
    state_t               state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic                 sticky_ovf_q;
    logic                 edge_pulse;

    sync_edge_detect u_sync_edge (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .signal_in  (signal_in),
        .edge_out   (edge_pulse)
    );

    // NOTE: every output and state_d gets a default before the case so no
    // path through the block leaves a signal unassigned (which would infer
    // a latch).
    always_comb begin
        state_d          = state_q;
        cnt_reset_out    = !reset_n_in;   // chain held clear while in reset
        cnt_enable_out   = 1'b0;
        cnt_pulse_out    = 1'b0;
        result_valid_out = 1'b0;
        busy_out         = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start_in || continuous_in) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                cnt_reset_out = 1'b1;
                state_d       = ST_GATE;
            end
            ST_GATE: begin
                cnt_enable_out = 1'b1;
                cnt_pulse_out  = edge_pulse;
                if (timer_q == '0) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                result_valid_out = 1'b1;
                if (result_ready_in) state_d = continuous_in ? ST_CLEAR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over every other transition, including a handshake.
        if (abort_in && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Gate timer counts GATE_CYCLES-1 down to 0, so GATE lasts GATE_CYCLES.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            timer_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            timer_q <= TIMER_W'(GATE_CYCLES - 1);
        end else if (state_q == ST_GATE && timer_q != '0) begin
            timer_q <= timer_q - TIMER_W'(1);
        end
    end

    // Sticky overflow: an overflow on the last GATE cycle lands here on the
    // same edge that enters LATCH, so LATCH always sees it.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sticky_ovf_q <= 1'b0;
        end else if (state_q == ST_CLEAR) begin
            sticky_ovf_q <= 1'b0;
        end else if (cnt_pulse_out && overflow_in) begin
            sticky_ovf_q <= 1'b1;
        end
    end

    // NOTE: the result register is a plain register, not a memory, so it is
    // reset like any other flop and reads 0 until the first measurement.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            result_out   <= '0;
            overflow_out <= 1'b0;
        end else if (state_q == ST_LATCH && !abort_in) begin
            result_out   <= digits_in;
            overflow_out <= sticky_ovf_q;
        end
    end

endmodule

// File: tb/tb_freq_gate_controller.sv
// Directed bench for freq_gate_controller with a behavioural BCD digit chain.
module tb_freq_gate_controller;

    localparam int ND = 3;
    localparam int W  = 4 * ND;

    logic         clk_in = 1'b0;
    logic         reset_n_in;
    logic         signal_in = 1'b0;
    logic         start_in, continuous_in, abort_in, result_ready_in;
    logic         start_l, ready_l;

    // main instance (GATE_CYCLES = 100)
    logic [W-1:0] digits, result;
    logic         ovf_in, cnt_reset, cnt_enable, cnt_pulse, ovf_out, valid, busy;
    // long-gate instance (GATE_CYCLES = 2500)
    logic [W-1:0] digits_l, result_l;
    logic         ovf_in_l, cnt_reset_l, cnt_enable_l, cnt_pulse_l, ovf_out_l, valid_l, busy_l;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0, enable_cnt = 0, clear_cnt = 0;
    int sig_period = 0;

    always #5 clk_in = ~clk_in;

    freq_gate_controller #(.GATE_CYCLES(100), .NUM_DIGITS(ND)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .signal_in(signal_in),
        .start_in(start_in), .continuous_in(continuous_in), .abort_in(abort_in),
        .digits_in(digits), .overflow_in(ovf_in),
        .cnt_reset_out(cnt_reset), .cnt_enable_out(cnt_enable), .cnt_pulse_out(cnt_pulse),
        .result_out(result), .overflow_out(ovf_out),
        .result_valid_out(valid), .result_ready_in(result_ready_in), .busy_out(busy)
    );

    freq_gate_controller #(.GATE_CYCLES(2500), .NUM_DIGITS(ND)) dut_long (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .signal_in(signal_in),
        .start_in(start_l), .continuous_in(1'b0), .abort_in(1'b0),
        .digits_in(digits_l), .overflow_in(ovf_in_l),
        .cnt_reset_out(cnt_reset_l), .cnt_enable_out(cnt_enable_l), .cnt_pulse_out(cnt_pulse_l),
        .result_out(result_l), .overflow_out(ovf_out_l),
        .result_valid_out(valid_l), .result_ready_in(ready_l), .busy_out(busy_l)
    );

    // Behavioural 3-digit BCD chain: carry out of the MSD when counting at 999.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] d);
        logic [W-1:0] r;
        logic         carry;
        r = d;
        carry = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
                else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk_in) begin
        if (cnt_reset) digits <= '0;
        else if (cnt_enable && cnt_pulse) digits <= bcd_inc(digits);
        if (cnt_reset_l) digits_l <= '0;
        else if (cnt_enable_l && cnt_pulse_l) digits_l <= bcd_inc(digits_l);
    end
    assign ovf_in   = cnt_pulse && cnt_enable && (digits == 12'h999);
    assign ovf_in_l = cnt_pulse_l && cnt_enable_l && (digits_l == 12'h999);

    // Free-running cumulative event counters, sampled on the falling edge.
    always @(negedge clk_in) begin
        if (cnt_pulse === 1'b1)  pulse_cnt++;
        if (cnt_enable === 1'b1) enable_cnt++;
        if (cnt_reset === 1'b1)  clear_cnt++;
    end

    // Periodic signal generator: sig_period cycles per period, one rising edge each.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (sig_period < 2) signal_in = 1'b0;
            else begin
                phase = (phase + 1 >= sig_period) ? 0 : phase + 1;
                signal_in = (phase < sig_period / 2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    task automatic wait_valid(input string name, input int bound);
        int k;
        k = 0;
        while (valid !== 1'b1 && k < bound) begin
            step();
            k++;
        end
        check({name, " valid seen"}, 32'(valid), 32'd1);
    endtask

    task automatic set_period(input int p);
        sig_period = p;
        step(2 * p + 6);
    endtask

    typedef struct {
        int           period;
        logic [W-1:0] exp_result;
        int           exp_pulses;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p0, e0, c0, k, bad;
        logic [W-1:0] held;

        vecs[0] = '{2,  12'h050, 50};
        vecs[1] = '{4,  12'h025, 25};
        vecs[2] = '{5,  12'h020, 20};
        vecs[3] = '{10, 12'h010, 10};
        vecs[4] = '{20, 12'h005, 5};
        vecs[5] = '{25, 12'h004, 4};
        vecs[6] = '{50, 12'h002, 2};

        reset_n_in = 1'b0;
        start_in = 0; continuous_in = 0; abort_in = 0; result_ready_in = 0;
        start_l = 0; ready_l = 0;

        // Reset state
        #12;
        check("rst cnt_reset", 32'(cnt_reset), 32'd1);
        check("rst cnt_enable", 32'(cnt_enable), 32'd0);
        check("rst cnt_pulse", 32'(cnt_pulse), 32'd0);
        check("rst valid", 32'(valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst overflow", 32'(ovf_out), 32'd0);
        step(2);
        reset_n_in = 1'b1;
        step(2);
        check("idle busy", 32'(busy), 32'd0);
        check("idle cnt_reset", 32'(cnt_reset), 32'd0);

        // Table: single measurements at several signal periods
        foreach (vecs[i]) begin
            set_period(vecs[i].period);
            p0 = pulse_cnt; e0 = enable_cnt; c0 = clear_cnt;
            start_in = 1'b1;
            step();
            start_in = 1'b0;
            wait_valid($sformatf("vec%0d", i), 300);
            check($sformatf("vec%0d pulses", i), 32'(pulse_cnt - p0), 32'(vecs[i].exp_pulses));
            check($sformatf("vec%0d enable cycles", i), 32'(enable_cnt - e0), 32'd100);
            check($sformatf("vec%0d clear cycles", i), 32'(clear_cnt - c0), 32'd1);
            check($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].exp_result));
            check($sformatf("vec%0d overflow", i), 32'(ovf_out), 32'd0);
            step(3);
            check($sformatf("vec%0d valid held", i), 32'(valid), 32'd1);
            result_ready_in = 1'b1;
            step();
            result_ready_in = 1'b0;
            check($sformatf("vec%0d idle after handshake", i), 32'(busy), 32'd0);
        end

        // Long gate: 1250 edges wrap the 3-digit chain -> 250 with overflow
        set_period(2);
        start_l = 1'b1;
        step();
        start_l = 1'b0;
        k = 0;
        while (valid_l !== 1'b1 && k < 3000) begin
            step();
            k++;
        end
        check("long valid seen", 32'(valid_l), 32'd1);
        check("long result", 32'(result_l), 32'h250);
        check("long overflow", 32'(ovf_out_l), 32'd1);
        ready_l = 1'b1;
        step();
        ready_l = 1'b0;
        check("long idle", 32'(busy_l), 32'd0);

        // Continuous mode with ready tied high
        set_period(10);
        result_ready_in = 1'b1;
        continuous_in = 1'b1;
        for (int m = 0; m < 3; m++) begin
            wait_valid($sformatf("cont%0d", m), 300);
            check($sformatf("cont%0d result", m), 32'(result), 32'h010);
            if (m == 2) begin
                continuous_in = 1'b0;
                step();
                check("cont stop idle", 32'(busy), 32'd0);
            end else begin
                step();
                check($sformatf("cont%0d clear after handshake", m), 32'(cnt_reset), 32'd1);
                step();
                check($sformatf("cont%0d clear one cycle", m), 32'(cnt_reset), 32'd0);
            end
        end
        result_ready_in = 1'b0;

        // Abort at gate cycle 50
        set_period(5);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        k = 0;
        while (cnt_enable !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        check("abort gate reached", 32'(cnt_enable), 32'd1);
        step(49);
        abort_in = 1'b1;
        step();
        abort_in = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort cnt_enable", 32'(cnt_enable), 32'd0);
        bad = 0;
        for (int c = 0; c < 150; c++) begin
            if (valid !== 1'b0 || busy !== 1'b0) bad++;
            step();
        end
        check("abort no valid/busy", 32'(bad), 32'd0);
        check("abort result kept", 32'(result), 32'h010);

        // start while busy ignored; ready held low 20 cycles
        set_period(20);
        c0 = clear_cnt;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        step(40);
        start_in = 1'b1;   // mid-GATE, must be ignored
        step();
        start_in = 1'b0;
        wait_valid("busy-start", 300);
        check("busy-start result", 32'(result), 32'h005);
        held = result;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) start_in = 1'b1;   // during HOLD, must not be queued
            if (c == 6) start_in = 1'b0;
            step();
            if (valid !== 1'b1 || result !== held || cnt_reset !== 1'b0) bad++;
        end
        check("hold stable 20 cycles", 32'(bad), 32'd0);
        check("busy-start single clear", 32'(clear_cnt - c0), 32'd1);
        result_ready_in = 1'b1;
        step();
        result_ready_in = 1'b0;
        step(2);
        check("start not queued", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of GATE
        set_period(2);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        step(32);
        check("pre-reset in gate", 32'(cnt_enable), 32'd1);
        #1;
        reset_n_in = 1'b0;
        #1;
        check("async rst cnt_reset", 32'(cnt_reset), 32'd1);
        check("async rst cnt_enable", 32'(cnt_enable), 32'd0);
        check("async rst cnt_pulse", 32'(cnt_pulse), 32'd0);
        check("async rst valid", 32'(valid), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst result", 32'(result), 32'd0);
        check("async rst overflow", 32'(ovf_out), 32'd0);
        step(3);
        reset_n_in = 1'b1;
        p0 = pulse_cnt;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (busy !== 1'b0) bad++;
        end
        check("post-reset idle", 32'(bad), 32'd0);
        check("post-reset no pulses", 32'(pulse_cnt - p0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
